// File: rtl/mux_lut_cell.sv
// K-input LUT cell: 2:1 mux tree over a serially loaded, atomically committed table.
// Optional table readback port: define MUX_LUT_READBACK_EN.
module mux_lut_cell #(
    parameter int K = 2,
    parameter logic [2**K-1:0] INIT = {{(2**K-1){1'b0}}, 1'b1} << (2**K-1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [K-1:0] in_sel,
    output logic         out_valid,
    output logic         y,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic         cfg_bit,
    input  logic         cfg_abort,
`ifdef MUX_LUT_READBACK_EN
    output logic [2**K-1:0] table_q,
`endif
    output logic         cfg_done
);

    localparam int N  = 2**K;
    localparam int CW = K + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_table;
    logic [N-1:0]  r_shadow;
    logic [CW-1:0] r_cnt;
    logic          r_y;
    logic          r_ov;
    logic          r_done;
    logic          w_accept;
    logic          w_cnt_clr;
    logic          w_commit;
    logic          w_bit;

    logic [K:0][N-1:0] w_lvl;

    assign w_lvl[0] = r_table;

    // Level l+1 keeps N>>(l+1) live entries; upper bits are tied off.
    for (genvar l = 0; l < K; l++) begin : g_lvl
        for (genvar j = 0; j < N; j++) begin : g_bit
            if (j < (N >> (l + 1))) begin : g_mux
                assign w_lvl[l+1][j] = in_sel[l] ? w_lvl[l][2*j+1]
                                                 : w_lvl[l][2*j];
            end else begin : g_tie
                assign w_lvl[l+1][j] = 1'b0;
            end
        end
    end

    assign w_bit = w_lvl[K][0];

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_cnt_clr = 1'b0;
        w_commit  = 1'b0;
        cfg_ready = 1'b1;
        unique case (r_state)
            S_IDLE, S_LOAD: begin
                if (cfg_abort) begin
                    w_next    = S_IDLE;
                    w_cnt_clr = 1'b1;
                end else if (cfg_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        w_next = S_COMMIT;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_COMMIT: begin
                cfg_ready = 1'b0;
                w_commit  = 1'b1;
                w_cnt_clr = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next    = S_IDLE;
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_table  <= INIT;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_commit;
            if (w_accept) begin
                r_shadow[r_cnt[K-1:0]] <= cfg_bit;
                r_cnt <= r_cnt + 1'b1;
            end else if (w_cnt_clr) begin
                r_cnt <= '0;
            end
            if (w_commit) begin
                r_table <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ov <= 1'b0;
            r_y  <= 1'b0;
        end else begin
            r_ov <= in_valid;
            if (in_valid) begin
                r_y <= w_bit;
            end
        end
    end

    assign out_valid = r_ov;
    assign y         = r_y;
    assign cfg_done  = r_done;
`ifdef MUX_LUT_READBACK_EN
    assign table_q   = r_table;
`endif

endmodule

// File: tb/tb_mux_lut_cell.sv
// Directed bench for mux_lut_cell with K=2 and K=3 instances.
// Readback checks are active when MUX_LUT_READBACK_EN is defined.
module tb_mux_lut_cell;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_sel;
    logic       out_valid;
    logic       y;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_bit;
    logic       cfg_abort;
    logic       cfg_done;

    logic       k3_in_valid;
    logic [2:0] k3_in_sel;
    logic       k3_out_valid;
    logic       k3_y;
    logic       k3_cfg_valid;
    logic       k3_cfg_ready;
    logic       k3_cfg_bit;
    logic       k3_cfg_abort;
    logic       k3_cfg_done;

`ifdef MUX_LUT_READBACK_EN
    logic [3:0] tq2;
    logic [7:0] tq3;
`endif

    int n_pass;
    int n_total;

    mux_lut_cell #(.K(2)) u2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .y         (y),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_bit   (cfg_bit),
        .cfg_abort (cfg_abort),
`ifdef MUX_LUT_READBACK_EN
        .table_q   (tq2),
`endif
        .cfg_done  (cfg_done)
    );

    mux_lut_cell #(.K(3)) u3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (k3_in_valid),
        .in_sel    (k3_in_sel),
        .out_valid (k3_out_valid),
        .y         (k3_y),
        .cfg_valid (k3_cfg_valid),
        .cfg_ready (k3_cfg_ready),
        .cfg_bit   (k3_cfg_bit),
        .cfg_abort (k3_cfg_abort),
`ifdef MUX_LUT_READBACK_EN
        .table_q   (tq3),
`endif
        .cfg_done  (k3_cfg_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic eval2(input string tag, input logic [1:0] s,
                         input logic e);
        in_valid = 1'b1;
        in_sel   = s;
        step();
        chk(tag, {7'd0, y}, {7'd0, e});
        chk({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
    endtask

    logic [7:0] maj;
    logic [7:0] k3_exp;

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_sel       = '0;
        cfg_valid    = 1'b0;
        cfg_bit      = 1'b0;
        cfg_abort    = 1'b0;
        k3_in_valid  = 1'b0;
        k3_in_sel    = '0;
        k3_cfg_valid = 1'b0;
        k3_cfg_bit   = 1'b0;
        k3_cfg_abort = 1'b0;
        maj          = 8'hE8;
        k3_exp       = 8'b1110_1000;

        #7;
        chk("rst_y", {7'd0, y}, 8'd0);
        chk("rst_ov", {7'd0, out_valid}, 8'd0);
        chk("rst_done", {7'd0, cfg_done}, 8'd0);
        chk("rst_ready", {7'd0, cfg_ready}, 8'd1);
`ifdef MUX_LUT_READBACK_EN
        chk("rst_tq", {4'd0, tq2}, 8'h08);
`endif
        #5 rst_n = 1'b1;
        step();

        eval2("and0", 2'd0, 1'b0);
        eval2("and1", 2'd1, 1'b0);
        eval2("and2", 2'd2, 1'b0);
        eval2("and3", 2'd3, 1'b1);
        in_valid = 1'b0;
        step();
        chk("and_ov_end", {7'd0, out_valid}, 8'd0);
        chk("y_hold", {7'd0, y}, 8'd1);

        cfg_valid = 1'b1;
        cfg_bit = 1'b0; step();
        cfg_bit = 1'b1; step();
        chk("or_ready_mid", {7'd0, cfg_ready}, 8'd1);
        cfg_bit = 1'b1; step();
        cfg_bit = 1'b1; step();
        cfg_valid = 1'b0;
        chk("or_ready_commit", {7'd0, cfg_ready}, 8'd0);
        chk("or_done_early", {7'd0, cfg_done}, 8'd0);
        step();
        chk("or_done", {7'd0, cfg_done}, 8'd1);
        chk("or_ready_back", {7'd0, cfg_ready}, 8'd1);
        eval2("or1_in_done", 2'd1, 1'b1);
        chk("or_done_pulse", {7'd0, cfg_done}, 8'd0);
        eval2("or0", 2'd0, 1'b0);
        eval2("or2", 2'd2, 1'b1);
        eval2("or3", 2'd3, 1'b1);
        in_valid = 1'b0;
`ifdef MUX_LUT_READBACK_EN
        chk("or_tq", {4'd0, tq2}, 8'h0E);
`endif

        cfg_valid = 1'b1;
        cfg_bit = 1'b0; step();
        cfg_bit = 1'b0; step();
        cfg_bit = 1'b1; cfg_abort = 1'b1; step();
        cfg_abort = 1'b0; cfg_valid = 1'b0;
        chk("abort_ready", {7'd0, cfg_ready}, 8'd1);
        step();
        chk("abort_nodone", {7'd0, cfg_done}, 8'd0);
        eval2("abort_tbl3", 2'd3, 1'b1);
        eval2("abort_tbl0", 2'd0, 1'b0);
        in_valid = 1'b0;

        cfg_valid = 1'b1;
        cfg_bit = 1'b0; step();
        cfg_bit = 1'b1; step();
        cfg_bit = 1'b1;
        in_valid = 1'b1; in_sel = 2'd3;
        step();
        chk("load_uses_old", {7'd0, y}, 8'd1);
        cfg_bit = 1'b0; in_valid = 1'b0;
        step();
        chk("xor_commit", {7'd0, cfg_ready}, 8'd0);
        cfg_valid = 1'b0;
        in_valid = 1'b1; in_sel = 2'd3;
        step();
        chk("commit_edge_old", {7'd0, y}, 8'd1);
        chk("xor_done", {7'd0, cfg_done}, 8'd1);
        step();
        chk("xor3", {7'd0, y}, 8'd0);
        eval2("xor1", 2'd1, 1'b1);
        eval2("xor0", 2'd0, 1'b0);
        in_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            k3_cfg_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            k3_cfg_valid = 1'b1;
            k3_cfg_bit = maj[i];
            chk("k3_ready", {7'd0, k3_cfg_ready}, 8'd1);
            step();
        end
        k3_cfg_valid = 1'b0;
        chk("k3_commit", {7'd0, k3_cfg_ready}, 8'd0);
        step();
        chk("k3_done", {7'd0, k3_cfg_done}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            k3_in_valid = 1'b1;
            k3_in_sel = 3'(i);
            step();
            chk($sformatf("maj%0d", i), {7'd0, k3_y}, {7'd0, k3_exp[i]});
        end
        k3_in_valid = 1'b0;
`ifdef MUX_LUT_READBACK_EN
        chk("k3_tq", tq3, 8'hE8);
`endif

        cfg_valid = 1'b1;
        cfg_bit = 1'b1; step();
        cfg_bit = 1'b0; step();
        cfg_valid = 1'b0;
        in_valid = 1'b1; in_sel = 2'd1;
        step();
        chk("pre_rst_y", {7'd0, y}, 8'd1);
        k3_in_valid = 1'b1; k3_in_sel = 3'd7;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_y", {7'd0, y}, 8'd0);
        chk("arst_ov", {7'd0, out_valid}, 8'd0);
        chk("arst_done", {7'd0, cfg_done}, 8'd0);
        chk("arst_ready", {7'd0, cfg_ready}, 8'd1);
`ifdef MUX_LUT_READBACK_EN
        chk("arst_tq", {4'd0, tq2}, 8'h08);
        chk("arst_tq3", tq3, 8'h80);
`endif
        in_valid = 1'b0;
        k3_in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        eval2("init3", 2'd3, 1'b1);
        eval2("init1", 2'd1, 1'b0);
        in_valid = 1'b0;
        k3_in_valid = 1'b1; k3_in_sel = 3'd5;
        step();
        chk("k3_init5", {7'd0, k3_y}, 8'd0);
        k3_in_sel = 3'd7;
        step();
        chk("k3_init7", {7'd0, k3_y}, 8'd1);
        k3_in_valid = 1'b0;

        cfg_valid = 1'b1;
        cfg_bit = 1'b1; step();
        cfg_bit = 1'b1; step();
        cfg_bit = 1'b1; step();
        cfg_bit = 1'b0; step();
        cfg_valid = 1'b0;
        chk("post_rst_commit", {7'd0, cfg_ready}, 8'd0);
        step();
        chk("post_rst_done", {7'd0, cfg_done}, 8'd1);
        eval2("nand3", 2'd3, 1'b0);
        eval2("nand2", 2'd2, 1'b1);
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
